arb_mem_responder: RTL and testbench

- Target end of the arbiter memory interface driven by the per-core NTT engines (arb_req/arb_we/arb_addr/arb_wdata out; arb_valid/arb_rdata in).
- Services one request per cycle with no backpressure, into a local word-addressed RAM.
- Read data returns in order after a fixed latency. Writes are fire-and-forget.
- A low-priority backdoor port gives host preload and readback.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/arb_rd_pipe.sv | 47 ++++
 rtl/arb_mem_responder.sv | 185 ++++++++++++++++++
 tb/tb_arb_mem_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants for the arbiter memory interface: bus widths, word
// stride and the opcode values used by the per-core NTT engines.
package arb_pkg;

  localparam int unsigned ARB_ADDR_W     = 48;
  localparam int unsigned ARB_DATA_W     = 64;
  localparam int unsigned ARB_WORD_SHIFT = 3;

  localparam logic [7:0] LOAD  = 8'h02;
  localparam logic [7:0] STORE = 8'h04;
  localparam logic [7:0] NTT   = 8'h05;
  localparam logic [7:0] INTT  = 8'h06;
  localparam logic [7:0] MULT  = 8'h07;

  // A byte address is misaligned when any bit below the word stride is set.
  function automatic logic arb_is_misaligned(input logic [ARB_WORD_SHIFT-1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/arb_rd_pipe.sv
// Valid/data delay line for read responses. Data registers only load when
// the incoming valid is set, so the final stage keeps showing the most
// recent response while no new one is in flight. flush_i clears everything.
module arb_rd_pipe
  import arb_pkg::*;
#(
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned DATA_W = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o
);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;

  // Shift valid every cycle; advance data only alongside a valid entry.
  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    valid_d[0] = in_valid_i;
    if (in_valid_i) data_d[0] = in_data_i;
    for (int i = 1; i < int'(DEPTH); i++) begin
      valid_d[i] = valid_q[i-1];
      if (valid_q[i-1]) data_d[i] = data_q[i-1];
    end
  end

  // Stage registers with synchronous flush.
  always_ff @(posedge clk) begin
    if (flush_i) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q[DEPTH-1];
  assign out_data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/arb_mem_responder.sv
// Target end of the engines' arbiter memory interface: a word-addressed RAM
// answering one request per cycle, reads returning in order after
// RD_LATENCY cycles, plus a low-priority host backdoor.
// Optional build macro ARB_RESP_STATS_EN adds saturating read/write counters;
// without it rd_count/wr_count are constant zero.
module arb_mem_responder
  import arb_pkg::*;
#(
  parameter int unsigned       ADDR_W     = ARB_ADDR_W,
  parameter int unsigned       DATA_W     = ARB_DATA_W,
  parameter int unsigned       DEPTH_LOG  = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned       RD_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  // Handshake: the responder is always ready. Every cycle with arb_req=1 is
  // one accepted transaction; a read yields exactly one arb_valid cycle
  // RD_LATENCY cycles later, in request order; writes produce no response.
  input  logic                 arb_req,
  input  logic                 arb_we,
  input  logic [ADDR_W-1:0]    arb_addr,
  input  logic [DATA_W-1:0]    arb_wdata,
  output logic                 arb_valid,
  output logic [DATA_W-1:0]    arb_rdata,
  output logic                 err_align,
  output logic                 err_range,
  input  logic                 bd_en,
  input  logic                 bd_we,
  input  logic [DEPTH_LOG-1:0] bd_idx,
  input  logic [DATA_W-1:0]    bd_wdata,
  output logic [DATA_W-1:0]    bd_rdata,
  output logic                 bd_collide,
  output logic [31:0]          rd_count,
  output logic [31:0]          wr_count
);

  localparam int unsigned WORDS = 1 << DEPTH_LOG;
  localparam int unsigned IDX_HI = DEPTH_LOG + ARB_WORD_SHIFT - 1;

  logic [DATA_W-1:0] mem_q [WORDS];

  logic [ADDR_W-1:0]    off;
  logic [DEPTH_LOG-1:0] arb_idx;
  logic                 in_range;
  logic                 misaligned;
  logic                 arb_rd;
  logic                 bd_ok;
  logic                 mem_we;
  logic [DEPTH_LOG-1:0] mem_widx;
  logic [DATA_W-1:0]    mem_wdata;
  logic                 unused_off_lsb;

  logic                 s0_valid_q;
  logic [DATA_W-1:0]    s0_data_q;
  logic [DATA_W-1:0]    bd_rdata_q;
  logic                 err_align_q, err_align_d;
  logic                 err_range_q, err_range_d;
  logic                 bd_collide_q, bd_collide_d;

  // Address decode; a wrap below BASE_ADDR lands in the upper bits and is
  // therefore out of range. Misaligned requests use the truncated index.
  always_comb begin
    off        = arb_addr - BASE_ADDR;
    arb_idx    = off[IDX_HI:ARB_WORD_SHIFT];
    in_range   = (off[ADDR_W-1:IDX_HI+1] == '0);
    misaligned = arb_is_misaligned(arb_addr[ARB_WORD_SHIFT-1:0]);
    arb_rd     = arb_req & ~arb_we;
    bd_ok      = bd_en & ~arb_req;
  end

  assign unused_off_lsb = ^off[ARB_WORD_SHIFT-1:0];

  // Single write port: the arbiter owns it whenever it requests.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = arb_idx;
    mem_wdata = arb_wdata;
    if (arb_req) begin
      mem_we = arb_we & in_range;
    end else begin
      mem_we    = bd_ok & bd_we;
      mem_widx  = bd_idx;
      mem_wdata = bd_wdata;
    end
  end

  // RAM array, not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  // Read stage 0: registered RAM read; out-of-range reads return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_data_q  <= '0;
    end else begin
      s0_valid_q <= arb_rd;
      if (arb_rd) s0_data_q <= in_range ? mem_q[arb_idx] : '0;
    end
  end

  // Remaining RD_LATENCY-1 stages are pure delay.
  generate
    if (RD_LATENCY > 1) begin : g_pipe
      arb_rd_pipe #(
        .DEPTH (RD_LATENCY - 1),
        .DATA_W(DATA_W)
      ) u_rd_pipe (
        .clk        (clk),
        .flush_i    (rst),
        .in_valid_i (s0_valid_q),
        .in_data_i  (s0_data_q),
        .out_valid_o(arb_valid),
        .out_data_o (arb_rdata)
      );
    end else begin : g_no_pipe
      assign arb_valid = s0_valid_q;
      assign arb_rdata = s0_data_q;
    end
  endgenerate

  // Backdoor read port: one-cycle latency, holds between reads.
  always_ff @(posedge clk) begin
    if (rst) bd_rdata_q <= '0;
    else if (bd_ok && !bd_we) bd_rdata_q <= mem_q[bd_idx];
  end

  // Sticky error flags and the one-cycle collision pulse.
  always_comb begin
    err_align_d  = err_align_q | (arb_req & misaligned);
    err_range_d  = err_range_q | (arb_req & ~in_range);
    bd_collide_d = bd_en & arb_req;
  end

  // Status register bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_align_q  <= 1'b0;
      err_range_q  <= 1'b0;
      bd_collide_q <= 1'b0;
    end else begin
      err_align_q  <= err_align_d;
      err_range_q  <= err_range_d;
      bd_collide_q <= bd_collide_d;
    end
  end

  assign bd_rdata   = bd_rdata_q;
  assign err_align  = err_align_q;
  assign err_range  = err_range_q;
  assign bd_collide = bd_collide_q;

`ifdef ARB_RESP_STATS_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;

  // Saturating counters of accepted arbiter reads and writes.
  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (arb_rd && (rd_count_q != 32'hFFFF_FFFF)) rd_count_d = rd_count_q + 32'd1;
    if (arb_req && arb_we && (wr_count_q != 32'hFFFF_FFFF)) wr_count_d = wr_count_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_arb_mem_responder.sv
// Bench for arb_mem_responder: directed steps plus a randomized phase, all
// checked against a word-array memory model and an expected-response queue.
module tb_arb_mem_responder;

  localparam int unsigned    LAT   = 2;
  localparam longint unsigned BASE = 64'h0;
  localparam longint unsigned SPAN = 64'd8 * 64'd65536;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        arb_req, arb_we;
  logic [47:0] arb_addr;
  logic [63:0] arb_wdata;
  logic        arb_valid;
  logic [63:0] arb_rdata;
  logic        err_align, err_range;
  logic        bd_en, bd_we;
  logic [15:0] bd_idx;
  logic [63:0] bd_wdata, bd_rdata;
  logic        bd_collide;
  logic [31:0] rd_count, wr_count;

  arb_mem_responder #(
    .ADDR_W(48), .DATA_W(64), .DEPTH_LOG(16), .BASE_ADDR(48'h0), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .arb_req(arb_req), .arb_we(arb_we), .arb_addr(arb_addr), .arb_wdata(arb_wdata),
    .arb_valid(arb_valid), .arb_rdata(arb_rdata),
    .err_align(err_align), .err_range(err_range),
    .bd_en(bd_en), .bd_we(bd_we), .bd_idx(bd_idx), .bd_wdata(bd_wdata),
    .bd_rdata(bd_rdata), .bd_collide(bd_collide),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [63:0]  ref_mem [65536];
  logic [63:0]  exp_q [$];
  int           exp_due_q [$];
  logic [63:0]  last_rdata;
  logic         exp_align, exp_range, exp_collide;
  logic [63:0]  exp_bd;
  int unsigned  exp_rd, exp_wr;
  int           pulse_cnt;
  bit           mon_en = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp(input int unsigned v);
`ifdef ARB_RESP_STATS_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  // One cycle of stimulus: present inputs, update the model, take the edge.
  task automatic drive(input logic req, input logic we, input logic [47:0] addr,
                       input logic [63:0] wdata, input logic bden, input logic bdwe,
                       input logic [15:0] bdidx, input logic [63:0] bdwdata);
    longint unsigned a;
    int unsigned     w;
    bit              inr, mis, col, bdrd;
    logic [63:0]     bdnext;
    arb_req = req; arb_we = we; arb_addr = addr; arb_wdata = wdata;
    bd_en = bden; bd_we = bdwe; bd_idx = bdidx; bd_wdata = bdwdata;
    a      = 64'(addr);
    inr    = (a >= BASE) && (a < BASE + SPAN);
    w      = inr ? int'((a - BASE) / 8) : 0;
    mis    = (a % 8) != 0;
    col    = req && bden;
    bdrd   = !req && bden && !bdwe;
    bdnext = 64'h0;
    if (req && !we) begin
      exp_due_q.push_back(cyc + int'(LAT));
      exp_q.push_back(inr ? ref_mem[w] : 64'h0);
    end
    if (req && we && inr) ref_mem[w] = wdata;
    if (!req && bden && bdwe) ref_mem[bdidx] = bdwdata;
    if (bdrd) bdnext = ref_mem[bdidx];
    @(posedge clk); #1;
    if (req) begin
      if (mis) exp_align = 1'b1;
      if (!inr) exp_range = 1'b1;
      if (we) exp_wr++; else exp_rd++;
    end
    exp_collide = col;
    if (bdrd) exp_bd = bdnext;
    arb_req = 1'b0; bd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 48'h0, 64'h0, 0, 0, 16'h0, 64'h0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; arb_req = 1'b0; bd_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      while (exp_due_q.size() > 0 && exp_due_q[exp_due_q.size()-1] >= cyc) begin
        void'(exp_due_q.pop_back());
        void'(exp_q.pop_back());
      end
      exp_align = 0; exp_range = 0; exp_collide = 0; exp_bd = 64'h0;
      exp_rd = 0; exp_wr = 0; last_rdata = 64'h0;
    end
    rst = 1'b0;
  endtask

  // Scoreboard: every cycle compare responses and status against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
        check("arb_valid", 64'(arb_valid), 64'd1);
        check("arb_rdata", arb_rdata, exp_q[0]);
        last_rdata = exp_q[0];
        void'(exp_due_q.pop_front());
        void'(exp_q.pop_front());
      end else begin
        check("arb_valid_idle", 64'(arb_valid), 64'd0);
        check("arb_rdata_hold", arb_rdata, last_rdata);
      end
      if (arb_valid) pulse_cnt++;
      check("err_align", 64'(err_align), 64'(exp_align));
      check("err_range", 64'(err_range), 64'(exp_range));
      check("bd_collide", 64'(bd_collide), 64'(exp_collide));
      check("bd_rdata", bd_rdata, exp_bd);
      check("rd_count", 64'(rd_count), 64'(stat_exp(exp_rd)));
      check("wr_count", 64'(wr_count), 64'(stat_exp(exp_wr)));
    end
  end

  // Watchdog
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // Directed and random stimulus
  initial begin
    logic [63:0]  d;
    logic [47:0]  a;
    int unsigned  w, op;
    arb_req = 0; arb_we = 0; arb_addr = '0; arb_wdata = '0;
    bd_en = 0; bd_we = 0; bd_idx = '0; bd_wdata = '0;
    last_rdata = '0; exp_align = 0; exp_range = 0; exp_collide = 0;
    exp_bd = '0; exp_rd = 0; exp_wr = 0; pulse_cnt = 0;

    do_reset(2);
    check("rst_arb_valid", 64'(arb_valid), 64'd0);
    check("rst_arb_rdata", arb_rdata, 64'd0);
    check("rst_err_align", 64'(err_align), 64'd0);
    check("rst_err_range", 64'(err_range), 64'd0);
    check("rst_bd_rdata", bd_rdata, 64'd0);
    check("rst_bd_collide", 64'(bd_collide), 64'd0);
    check("rst_rd_count", 64'(rd_count), 64'd0);
    check("rst_wr_count", 64'(wr_count), 64'd0);
    mon_en = 1'b1;

    // Backdoor preload and readback
    for (int i = 0; i < 4096; i++) drive(0, 0, 48'h0, 64'h0, 1, 1, 16'(i), 64'(i * 3));
    drive(0, 0, 48'h0, 64'h0, 1, 0, 16'd5, 64'h0);
    check("bd_read_idx5", bd_rdata, 64'd15);

    // Reset in the middle of a read burst
    for (int i = 0; i < 10; i++) drive(1, 0, 48'((200 + i) * 8), 64'h0, 0, 0, 16'h0, 64'h0);
    do_reset(1);
    check("mid_rst_valid", 64'(arb_valid), 64'd0);
    check("mid_rst_rdata", arb_rdata, 64'd0);
    for (int i = 10; i < 100; i++) drive(1, 0, 48'((200 + i) * 8), 64'h0, 0, 0, 16'h0, 64'h0);
    idle(4);
    drive(0, 0, 48'h0, 64'h0, 1, 0, 16'd205, 64'h0);
    check("ram_kept_205", bd_rdata, 64'd615);

    // Engine-style burst of 4096 reads, then 4096 writes
    do_reset(1);
    pulse_cnt = 0;
    for (int k = 0; k < 4096; k++) drive(1, 0, 48'(k * 8), 64'h0, 0, 0, 16'h0, 64'h0);
    idle(4);
    check("burst_pulses", 64'(pulse_cnt), 64'd4096);
    for (int k = 0; k < 4096; k++) drive(1, 1, 48'(k * 8), {$urandom, $urandom}, 0, 0, 16'h0, 64'h0);
    check("stats_rd_4096", 64'(rd_count), 64'(stat_exp(4096)));
    check("stats_wr_4096", 64'(wr_count), 64'(stat_exp(4096)));

    // Write then read the same word on the next cycle
    drive(1, 1, 48'h40, 64'hDEADBEEF_0000_0001, 0, 0, 16'h0, 64'h0);
    drive(1, 0, 48'h40, 64'h0, 0, 0, 16'h0, 64'h0);
    idle(1);
    check("wbr_valid", 64'(arb_valid), 64'd1);
    check("wbr_rdata", arb_rdata, 64'hDEADBEEF_0000_0001);

    // Misaligned read serviced at word 0
    drive(1, 0, 48'h3, 64'h0, 0, 0, 16'h0, 64'h0);
    check("err_align_set", 64'(err_align), 64'd1);
    idle(1);
    check("misalign_rdata", arb_rdata, ref_mem[0]);

    // Out-of-range read returns zero, out-of-range write is dropped
    drive(1, 0, 48'h80000, 64'h0, 0, 0, 16'h0, 64'h0);
    idle(1);
    check("oor_valid", 64'(arb_valid), 64'd1);
    check("oor_rdata", arb_rdata, 64'd0);
    check("oor_err_range", 64'(err_range), 64'd1);
    drive(1, 1, 48'h80000, 64'h0BAD_0BAD_0BAD_0BAD, 0, 0, 16'h0, 64'h0);
    for (int i = 0; i < 16; i++) drive(0, 0, 48'h0, 64'h0, 1, 0, 16'(i), 64'h0);
    drive(0, 0, 48'h0, 64'h0, 1, 0, 16'd0, 64'h0);
    check("oor_word0", bd_rdata, ref_mem[0]);

    // Last word of the window
    drive(1, 1, 48'h7FFF8, 64'hA5A5_0000_FFFF_1234, 0, 0, 16'h0, 64'h0);
    drive(1, 0, 48'h7FFF8, 64'h0, 0, 0, 16'h0, 64'h0);
    drive(1, 0, 48'h7FFFF, 64'h0, 0, 0, 16'h0, 64'h0);
    idle(1);
    check("top_word", arb_rdata, 64'hA5A5_0000_FFFF_1234);

    // Backdoor collision
    drive(1, 0, 48'd160, 64'h0, 1, 1, 16'd7, 64'h5555_5555_5555_5555);
    check("collide_pulse", 64'(bd_collide), 64'd1);
    idle(1);
    check("collide_clear", 64'(bd_collide), 64'd0);
    drive(0, 0, 48'h0, 64'h0, 1, 0, 16'd7, 64'h0);
    check("collide_ram_kept", bd_rdata, ref_mem[7]);

    // Randomized mixed traffic
    for (int n = 0; n < 600; n++) begin
      w  = $urandom_range(0, 4095);
      a  = 48'(w * 8);
      if ($urandom_range(0, 7) == 0) a = a + 48'($urandom_range(1, 7));
      if ($urandom_range(0, 15) == 0) a = 48'h80000 + 48'($urandom_range(0, 4095) * 8);
      d  = {$urandom, $urandom};
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: drive(1, 0, a, 64'h0, 0, 0, 16'h0, 64'h0);
        4, 5, 6:    drive(1, 1, a, d, 0, 0, 16'h0, 64'h0);
        7:          drive(0, 0, 48'h0, 64'h0, 1, 0, 16'(w), 64'h0);
        8:          drive(0, 0, 48'h0, 64'h0, 1, 1, 16'(w), d);
        default:    drive(1, 0, a, 64'h0, 1, $urandom_range(0, 1) == 1, 16'(w), d);
      endcase
    end

    idle(4);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("final_err_align", 64'(err_align), 64'd1);
    check("final_err_range", 64'(err_range), 64'd1);
    check("final_rd_count", 64'(rd_count), 64'(stat_exp(exp_rd)));
    check("final_wr_count", 64'(wr_count), 64'(stat_exp(exp_wr)));

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
